// File: rtl/march_bist_ctrl_pkg.sv
// Shared types for the March C- BIST controller: FSM states, op codes and the
// March C- element table (direction, op count, ops in execution order).
package bist_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;
    typedef enum logic [1:0] {OP_W0, OP_W1, OP_R0, OP_R1} op_e;

    typedef struct packed {
        logic       down;
        logic [1:0] nops;
        op_e        op0;
        op_e        op1;
    } march_elem_t;

    localparam int NUM_ELEM = 6;

    // M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0)
    localparam march_elem_t MARCH_TBL [NUM_ELEM] = '{
        '{1'b0, 2'd1, OP_W0, OP_W0},
        '{1'b0, 2'd2, OP_R0, OP_W1},
        '{1'b0, 2'd2, OP_R1, OP_W0},
        '{1'b1, 2'd2, OP_R0, OP_W1},
        '{1'b1, 2'd2, OP_R1, OP_W0},
        '{1'b0, 2'd1, OP_R0, OP_R0}
    };
endpackage

// File: rtl/march_bist_ctrl_if.sv
// RAM port bundle between the BIST controller (master) and a simple dual-port RAM (slave).
interface march_bist_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic [AW-1:0] ram_rd_addr;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_wr_en;
    logic [DW-1:0] ram_rd_data;

    modport master (output ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_en,
                    input  ram_rd_data);
    modport slave  (input  ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_en,
                    output ram_rd_data);
endinterface

// File: rtl/march_bist_ctrl_bg_gen.sv
// Background word generator: bg 0 is all zeros, bg k>=1 sets bit i to bit (k-1) of i.
module bist_bg_gen #(
    parameter int DW = 8
) (
    input  logic [1:0]    bg,
    output logic [DW-1:0] word0,
    output logic [DW-1:0] word1
);
    for (genvar i = 0; i < DW; i++) begin : g_bit
        localparam logic [3:0] IDX = 4'(i);
        assign word0[i] = (bg != 2'd0) && IDX[bg - 2'd1];
    end
    assign word1 = ~word0;
endmodule

// File: rtl/march_bist_ctrl.sv
// March C- RAM self-test controller: owns the RAM port mux, sequences elements and
// backgrounds, and records the first miscompare plus a saturating miscompare count.
module march_bist_ctrl
    import bist_pkg::*;
#(
    parameter int AW     = 10,
    parameter int DW     = 8,
    parameter int RD_LAT = 1,
    parameter int NUM_BG = 2,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop_on_fail,
    input  logic [AW-1:0]      usr_rd_addr,
    input  logic [AW-1:0]      usr_wr_addr,
    input  logic [DW-1:0]      usr_wr_data,
    input  logic               usr_wr_en,
    march_bist_ctrl_if.master  ram,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [AW-1:0]      fail_addr,
    output logic [DW-1:0]      fail_exp,
    output logic [DW-1:0]      fail_act,
    output logic [2:0]         fail_elem,
    output logic [1:0]         fail_bg,
    output logic [CNT_W-1:0]   fail_cnt
);
    state_e        state, state_nxt;
    logic [AW-1:0] addr;
    logic [2:0]    elem;
    logic          opi;
    logic [1:0]    bg, wcnt;
    logic          sof;
    march_elem_t   ent;
    op_e           cur_op;
    logic [DW-1:0] bg0, bg1, exp_word;
    logic          is_rd, op_last, addr_last, elem_last, seq_last;
    logic          cmp, mism, step, launch;

    bist_bg_gen #(.DW(DW)) u_bg (.bg(bg), .word0(bg0), .word1(bg1));

    always_comb begin
        ent       = MARCH_TBL[elem];
        cur_op    = opi ? ent.op1 : ent.op0;
        is_rd     = (cur_op == OP_R0) || (cur_op == OP_R1);
        exp_word  = ((cur_op == OP_W1) || (cur_op == OP_R1)) ? bg1 : bg0;
        op_last   = (ent.nops == 2'd1) || opi;
        addr_last = ent.down ? (addr == '0) : (addr == '1);
        elem_last = (elem == 3'(NUM_ELEM - 1));
        seq_last  = op_last && addr_last && elem_last && (bg == 2'(NUM_BG - 1));
        cmp       = (state == ST_WAIT) && (wcnt == 2'(RD_LAT));
        mism      = cmp && (ram.ram_rd_data != exp_word);
        step      = ((state == ST_ISSUE) && !is_rd) || cmp;
        launch    = start && ((state == ST_IDLE) || (state == ST_DONE));
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (is_rd)         state_nxt = ST_WAIT;
                else if (seq_last) state_nxt = ST_DONE;
            end
            ST_WAIT: if (cmp) state_nxt = ((mism && sof) || seq_last) ? ST_DONE : ST_ISSUE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    assign busy = (state == ST_ISSUE) || (state == ST_WAIT);
    assign done = (state == ST_DONE);
    assign pass = done && (fail_cnt == '0);

    // While busy the user write enable is dropped entirely; only BIST writes reach the RAM.
    always_comb begin
        ram.ram_rd_addr = busy ? addr : usr_rd_addr;
        ram.ram_wr_addr = busy ? addr : usr_wr_addr;
        ram.ram_wr_data = busy ? exp_word : usr_wr_data;
        ram.ram_wr_en   = busy ? ((state == ST_ISSUE) && !is_rd) : usr_wr_en;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0; elem <= '0; opi <= 1'b0; bg <= '0; wcnt <= '0; sof <= 1'b0;
            fail_addr <= '0; fail_exp <= '0; fail_act <= '0;
            fail_elem <= '0; fail_bg <= '0; fail_cnt <= '0;
        end else if (launch) begin
            addr <= '0; elem <= '0; opi <= 1'b0; bg <= '0; wcnt <= '0; sof <= stop_on_fail;
            fail_addr <= '0; fail_exp <= '0; fail_act <= '0;
            fail_elem <= '0; fail_bg <= '0; fail_cnt <= '0;
        end else begin
            if (state == ST_ISSUE)     wcnt <= 2'd1;
            else if (state == ST_WAIT) wcnt <= wcnt + 2'd1;
            if (mism) begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                if (fail_cnt == '0) begin
                    fail_addr <= addr;
                    fail_exp  <= exp_word;
                    fail_act  <= ram.ram_rd_data;
                    fail_elem <= elem;
                    fail_bg   <= bg;
                end
            end
            if (step) begin
                if (!op_last) begin
                    opi <= 1'b1;
                end else begin
                    opi <= 1'b0;
                    if (!addr_last) begin
                        addr <= ent.down ? addr - AW'(1) : addr + AW'(1);
                    end else if (!elem_last) begin
                        elem <= elem + 3'd1;
                        addr <= MARCH_TBL[elem + 3'd1].down ? '1 : '0;
                    end else begin
                        elem <= '0;
                        bg   <= bg + 2'd1;
                        addr <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl: two instances (read latency 1 and 2) on behavioural
// RAMs with injectable stuck-at and coupling faults; expectations flow through a queue.
module tb_march_bist_ctrl;
    logic       clk, rst, start1, start2, sof;
    logic [3:0] usr_rd_addr, usr_wr_addr;
    logic [7:0] usr_wr_data;
    logic       usr_wr_en;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [3:0] fail_addr1, fail_addr2;
    logic [7:0] fail_exp1, fail_act1, fail_exp2, fail_act2, fail_cnt1, fail_cnt2;
    logic [2:0] fail_elem1, fail_elem2;
    logic [1:0] fail_bg1, fail_bg2;
    logic       fault_sa, fault_cf;
    logic [7:0] mem1 [16];
    logic [7:0] mem2 [16];
    logic [7:0] rd2_q;

    march_bist_ctrl_if #(.AW(4), .DW(8)) ram1 ();
    march_bist_ctrl_if #(.AW(4), .DW(8)) ram2 ();

    march_bist_ctrl #(.AW(4), .DW(8), .RD_LAT(1), .NUM_BG(2), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop_on_fail(sof),
        .usr_rd_addr(usr_rd_addr), .usr_wr_addr(usr_wr_addr), .usr_wr_data(usr_wr_data),
        .usr_wr_en(usr_wr_en), .ram(ram1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_addr(fail_addr1), .fail_exp(fail_exp1), .fail_act(fail_act1),
        .fail_elem(fail_elem1), .fail_bg(fail_bg1), .fail_cnt(fail_cnt1));

    march_bist_ctrl #(.AW(4), .DW(8), .RD_LAT(2), .NUM_BG(2), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .stop_on_fail(sof),
        .usr_rd_addr(usr_rd_addr), .usr_wr_addr(usr_wr_addr), .usr_wr_data(usr_wr_data),
        .usr_wr_en(usr_wr_en), .ram(ram2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_addr(fail_addr2), .fail_exp(fail_exp2), .fail_act(fail_act2),
        .fail_elem(fail_elem2), .fail_bg(fail_bg2), .fail_cnt(fail_cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM 1: stuck-at-1 on bit 3 of word 5 (read side); writing all-ones to word 2 flips word 3.
    always @(posedge clk) begin
        ram1.ram_rd_data <= mem1[ram1.ram_rd_addr] |
                            ((fault_sa && ram1.ram_rd_addr == 4'd5) ? 8'h08 : 8'h00);
        if (ram1.ram_wr_en) begin
            mem1[ram1.ram_wr_addr] <= ram1.ram_wr_data;
            if (fault_cf && ram1.ram_wr_addr == 4'd2 && ram1.ram_wr_data == 8'hFF)
                mem1[3] <= ~mem1[3];
        end
    end

    always @(posedge clk) begin
        rd2_q            <= mem2[ram2.ram_rd_addr];
        ram2.ram_rd_data <= rd2_q;
        if (ram2.ram_wr_en) mem2[ram2.ram_wr_addr] <= ram2.ram_wr_data;
    end

    typedef struct { string tag; logic [31:0] val; } exp_t;
    exp_t sb[$];
    int   n_cmp = 0, n_err = 0;

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty: observed %0h with no expectation queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run1(output int cyc, output int wrs);
        cyc = 0; wrs = 0;
        while (busy1 && cyc < 5000) begin
            if (ram1.ram_wr_en) wrs++;
            cyc++;
            tick();
        end
    endtask

    int cyc, wrs;

    initial begin
        rst = 1'b0; start1 = 1'b0; start2 = 1'b0; sof = 1'b0;
        usr_rd_addr = '0; usr_wr_addr = '0; usr_wr_data = '0; usr_wr_en = 1'b0;
        fault_sa = 1'b0; fault_cf = 1'b0;
        tick(); tick();

        expect_v("rst_busy", 0); expect_v("rst_done", 0);
        expect_v("rst_pass", 0); expect_v("rst_fail_cnt", 0);
        check(32'(busy1)); check(32'(done1)); check(32'(pass1)); check(32'(fail_cnt1));
        rst = 1'b1;
        tick();

        // user pass-through while idle
        usr_wr_addr = 4'd7; usr_wr_data = 8'h5A; usr_wr_en = 1'b1; #1;
        expect_v("usr_wr_addr", 7); expect_v("usr_wr_data", 8'h5A); expect_v("usr_wr_en", 1);
        check(32'(ram1.ram_wr_addr)); check(32'(ram1.ram_wr_data)); check(32'(ram1.ram_wr_en));
        tick();
        usr_wr_en = 1'b0; usr_rd_addr = 4'd7; #1;
        expect_v("usr_rd_addr", 7);
        check(32'(ram1.ram_rd_addr));
        tick();
        expect_v("usr_rd_data", 8'h5A);
        check(32'(ram1.ram_rd_data));

        // fault-free run with user writes and extra start pulses during busy
        usr_wr_en = 1'b1; usr_wr_addr = 4'd9; usr_wr_data = 8'h33;
        expect_v("busy_wr_addr_c3", 3); expect_v("busy_wr_data_c3", 0);
        expect_v("busy_wr_en_c17", 0);
        expect_v("ff_busy_cycles", 480); expect_v("ff_done", 1); expect_v("ff_pass", 1);
        expect_v("ff_fail_cnt", 0); expect_v("ff_done_held", 1);
        start1 = 1'b1; tick(); start1 = 1'b0;
        cyc = 0;
        while (busy1 && cyc < 5000) begin
            if (cyc == 3) begin check(32'(ram1.ram_wr_addr)); check(32'(ram1.ram_wr_data)); end
            if (cyc == 17) check(32'(ram1.ram_wr_en));
            start1 = (cyc == 100 || cyc == 300);
            cyc++;
            tick();
        end
        start1 = 1'b0; usr_wr_en = 1'b0;
        check(32'(cyc)); check(32'(done1)); check(32'(pass1)); check(32'(fail_cnt1));
        tick(); tick(); tick();
        check(32'(done1));

        // stuck-at, run to completion
        fault_sa = 1'b1;
        expect_v("sa_busy_cycles", 480); expect_v("sa_elem", 1); expect_v("sa_addr", 5);
        expect_v("sa_exp", 0); expect_v("sa_act", 8'h08); expect_v("sa_bg", 0);
        expect_v("sa_pass", 0); expect_v("sa_cnt_gt1", 1);
        start1 = 1'b1; tick(); start1 = 1'b0;
        run1(cyc, wrs);
        check(32'(cyc)); check(32'(fail_elem1)); check(32'(fail_addr1)); check(32'(fail_exp1));
        check(32'(fail_act1)); check(32'(fail_bg1)); check(32'(pass1)); check(32'(fail_cnt1 > 1));

        // stuck-at with stop_on_fail: compare at busy cycle 32, 16+5 writes before it
        sof = 1'b1;
        expect_v("sof_busy_cycles", 33); expect_v("sof_writes", 21); expect_v("sof_done", 1);
        expect_v("sof_pass", 0); expect_v("sof_fail_cnt", 1); expect_v("sof_addr", 5);
        start1 = 1'b1; tick(); start1 = 1'b0; sof = 1'b0;
        run1(cyc, wrs);
        check(32'(cyc)); check(32'(wrs)); check(32'(done1));
        check(32'(pass1)); check(32'(fail_cnt1)); check(32'(fail_addr1));

        // coupling fault 2 -> 3
        fault_sa = 1'b0; fault_cf = 1'b1;
        expect_v("cf_elem", 1); expect_v("cf_addr", 3); expect_v("cf_exp", 0);
        expect_v("cf_act", 8'hFF); expect_v("cf_bg", 0); expect_v("cf_pass", 0);
        start1 = 1'b1; tick(); start1 = 1'b0;
        run1(cyc, wrs);
        check(32'(fail_elem1)); check(32'(fail_addr1)); check(32'(fail_exp1));
        check(32'(fail_act1)); check(32'(fail_bg1)); check(32'(pass1));
        fault_cf = 1'b0;

        // read latency 2, fault-free: 16 * 20 * 2 cycles
        expect_v("rl2_busy_cycles", 640); expect_v("rl2_done", 1);
        expect_v("rl2_pass", 1); expect_v("rl2_fail_cnt", 0);
        start2 = 1'b1; tick(); start2 = 1'b0;
        cyc = 0;
        while (busy2 && cyc < 5000) begin cyc++; tick(); end
        check(32'(cyc)); check(32'(done2)); check(32'(pass2)); check(32'(fail_cnt2));

        // reset in the middle of M3 (bg0 M3 spans busy cycles 112..159)
        fault_sa = 1'b1;
        expect_v("pre_rst_cnt_nz", 1);
        expect_v("mid_rst_busy", 0); expect_v("mid_rst_done", 0); expect_v("mid_rst_pass", 0);
        expect_v("mid_rst_cnt", 0); expect_v("mid_rst_addr", 0); expect_v("mid_rst_act", 0);
        expect_v("post_rst_wr_addr", 4'hC); expect_v("post_rst_wr_data", 8'h77);
        expect_v("post_rst_wr_en", 1);
        start1 = 1'b1; tick(); start1 = 1'b0;
        cyc = 0;
        while (busy1 && cyc < 130) begin cyc++; tick(); end
        check(32'(fail_cnt1 != 0));
        rst = 1'b0; #1;
        check(32'(busy1)); check(32'(done1)); check(32'(pass1));
        check(32'(fail_cnt1)); check(32'(fail_addr1)); check(32'(fail_act1));
        usr_wr_addr = 4'hC; usr_wr_data = 8'h77; usr_wr_en = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check(32'(ram1.ram_wr_addr)); check(32'(ram1.ram_wr_data)); check(32'(ram1.ram_wr_en));
        usr_wr_en = 1'b0; fault_sa = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
Parametrised next-generation RAM self-test controller. Runs a March C- algorithm over a simple dual-port RAM of configurable address/data width, repeats it over up to four data backgrounds, and supports configurable RAM read latency. It owns the RAM-port muxing between user traffic and test traffic. It captures the first failure's details and a saturating failure count, and can optionally stop on the first fail.

Parameters:
AW, 10, RAM address width; depth D = 2^AW
DW, 8, RAM data width (power of 2, >= 2)
RD_LAT, 1, RAM read latency in clk cycles (1..3)
NUM_BG, 2, number of data backgrounds run (1..min(4, log2(DW)+1))
CNT_W, 8, width of the failure counter

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle test request; sampled only in IDLE/DONE
stop_on_fail  in  1  1 = end test at first miscompare; sampled at start
usr_rd_addr  in  AW  user read address
usr_wr_addr  in  AW  user write address
usr_wr_data  in  DW  user write data
usr_wr_en  in  1  user write enable
ram_rd_addr  out  AW  to RAM read port
ram_wr_addr  out  AW  to RAM write port
ram_wr_data  out  DW  to RAM write data
ram_wr_en  out  1  to RAM write enable
ram_rd_data  in  DW  from RAM, valid RD_LAT cycles after address
busy  out  1  test in progress; RAM ports under BIST control
done  out  1  test finished; held until next start or reset
pass  out  1  valid when done: 1 = zero miscompares
fail_addr  out  AW  address of first miscompare
fail_exp  out  DW  expected data at first miscompare
fail_act  out  DW  actual data at first miscompare
fail_elem  out  3  March element index (0..5) of first miscompare
fail_bg  out  2  background index of first miscompare
fail_cnt  out  CNT_W  total miscompares, saturating

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, pass=0; all fail_* = 0; RAM ports select user inputs. Reset mid-test aborts immediately. RAM contents are left undefined.
- Mux: busy=0 -> ram_* = usr_* (combinational pass-through). busy=1 -> ram_* driven by BIST. usr_wr_en is ignored, ram_wr_en is forced to BIST value.
- Backgrounds: "0" word for bg k is defined as follows. k=0: all zeros. k>=1: bit i = bit (k-1) of i. For DW=8 this gives 0x00, 0xAA, 0xCC, 0xF0. The "1" word is the bitwise complement.
- March C- elements (per background): M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0). "Up" means address 0 to D-1. "Down" means D-1 to 0.
- Op timing:
  - A write op takes 1 cycle.
  - A read op takes 1+RD_LAT cycles: the address is issued in cycle 0, and the compare happens in cycle RD_LAT.
  - Within an element's multi-op step, ops run in sequence on the same address.
  - There are no idle cycles between addresses, elements or backgrounds.
  - Cycles per background = D*(5 + 5*(1+RD_LAT)). With RD_LAT=1 this is 15D.
- FSM states:
  - IDLE: on start go to RUN. Clear fail_*, fail_cnt and done. Latch stop_on_fail.
  - RUN: sub-states OP_ISSUE / RD_WAIT. After the last op of M5 on the last background, go to DONE.
  - DONE: done=1. pass=(fail_cnt==0). On start go to RUN, performing the same clears as IDLE->start.
- busy=1 from the cycle after start is sampled until the cycle DONE is entered.
- start while busy is ignored.
- Compare: a mismatch is ram_rd_data != expected. On mismatch, fail_cnt increments and saturates at all-ones. On the first mismatch only, capture fail_addr/exp/act/elem/bg.
- If stop_on_fail=1: the first mismatch goes to DONE on the next cycle with pass=0, and no further RAM writes are issued.
- Address counter is AW bits wide. Terminal detection is at D-1 (up) or 0 (down); there is no wrap-around write.

Decomposition:
- Package bist_pkg holds:
  - FSM state enum
  - op enum (W0,W1,R0,R1)
  - March table constant (per element: direction, op count, op list)
  - element count (6)
- Natural sub-module: bist_bg_gen, a combinational generator of the "0"/"1" background word from bg index and DW.
- Address/op sequencing and fail capture stay in the top module.

Test Plan:
- Fault-free RAM model, AW=4, DW=8, RD_LAT=1, NUM_BG=2; pulse start -> busy high for exactly 480 cycles, then done=1, pass=1, fail_cnt=0.
- Stuck-at-1 on bit 3 of address 5 -> first fail at M1, bg0: fail_elem=1, fail_addr=5, fail_exp=0x00, fail_act=0x08. pass=0, fail_cnt>1.
- Same fault with stop_on_fail=1 -> done asserted the cycle after the first compare; fail_cnt=1; no ram_wr_en after the fail.
- Coupling fault (write 1 to addr 2 flips addr 3) -> detected in M1 at addr 3 (expects 0x00, reads 0xFF, bg0); capture matches.
- RD_LAT=2, fault-free -> busy lasts D*20*NUM_BG cycles, pass=1. Reset asserted mid-M3 -> all outputs zero immediately and RAM ports follow usr_* on the next cycle.
- busy=0: user write 0x5A to addr 7, then read -> ram_* mirror usr_*. During busy, usr_wr_en=1 -> ram_wr_en/addr reflect only BIST. start pulses during busy do not restart the test.
